// File: rtl/ft245_sync_tx_if.sv
// ft245_sync_tx_if: upstream FIFO read port and FT2232H sync-245 bus bundle.
interface ft245_sync_tx_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 32
);
    logic                 fifo_empty_i;
    logic                 fifo_ren_o;
    logic [WIDTH-1:0]     fifo_rdata_i;
    logic                 ft_txe_n_i;
    logic                 ft_suspend_n_i;
    logic                 ft_wr_n_o;
    logic [WIDTH-1:0]     ft_data_o;
    logic                 ft_siwua_n_o;
    logic [CNT_WIDTH-1:0] words_o;
    logic                 busy_o;
    modport slave (
        input  fifo_empty_i, fifo_rdata_i, ft_txe_n_i, ft_suspend_n_i,
        output fifo_ren_o, ft_wr_n_o, ft_data_o, ft_siwua_n_o, words_o, busy_o
    );
    modport master (
        output fifo_empty_i, fifo_rdata_i, ft_txe_n_i, ft_suspend_n_i,
        input  fifo_ren_o, ft_wr_n_o, ft_data_o, ft_siwua_n_o, words_o, busy_o
    );
endinterface

// File: rtl/ft245_sync_tx.sv
// ft245_sync_tx: FT2232H sync-245 transmit engine with a 4-entry skid buffer.
// Define FT_TX_FLUSH_EN to add the SIWU idle-flush pulse (FLUSH_IDLE idle cycles).
module ft245_sync_tx #(
    parameter int WIDTH      = 8,
    parameter int CNT_WIDTH  = 32
`ifdef FT_TX_FLUSH_EN
    , parameter int FLUSH_IDLE = 64
`endif
) (
    input logic            clk_i,
    input logic            rst_n,
    ft245_sync_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STREAM, STALL, SUSP} state_t;
    state_t               r_state;
    logic [WIDTH-1:0]     r_buf [4];
    logic [1:0]           r_rd, r_wr;
    logic [2:0]           r_occ;
    logic                 r_rd_pend, r_wr_n, r_busy;
    logic [WIDTH-1:0]     r_data;
    logic [CNT_WIDTH-1:0] r_words;
    logic                 w_ren, w_pop, w_push;
    logic [2:0]           w_occ_nxt;
    logic [1:0]           w_rd_nxt;
    logic [WIDTH-1:0]     w_head_nxt;

    // A read is issued only while buffered plus in-flight words stay below 3, so 4 entries never overflow
    assign w_ren      = rst_n && !bus.fifo_empty_i && bus.ft_suspend_n_i && (r_occ + {2'b0, r_rd_pend}) < 3'd3;
    assign w_pop      = !r_wr_n && !bus.ft_txe_n_i;
    assign w_push     = r_rd_pend;
    assign w_occ_nxt  = r_occ + {2'b0, w_push} - {2'b0, w_pop};
    assign w_rd_nxt   = r_rd + {1'b0, w_pop};
    assign w_head_nxt = (w_push && r_wr == w_rd_nxt) ? bus.fifo_rdata_i : r_buf[w_rd_nxt];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
            r_state   <= IDLE;
            r_rd      <= '0;
            r_wr      <= '0;
            r_occ     <= '0;
            r_rd_pend <= 1'b0;
            r_wr_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_words   <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_wr] <= bus.fifo_rdata_i;
                r_wr        <= r_wr + 2'd1;
            end
            r_rd      <= w_rd_nxt;
            r_occ     <= w_occ_nxt;
            r_rd_pend <= w_ren;
            r_data    <= w_head_nxt;
            r_wr_n    <= !(w_occ_nxt != 3'd0 && !bus.ft_txe_n_i && bus.ft_suspend_n_i);
            r_busy    <= w_occ_nxt != 3'd0 || w_ren;
            r_words   <= r_words + CNT_WIDTH'(w_pop);
            if (!bus.ft_suspend_n_i) r_state <= SUSP;
            else case (r_state)
                IDLE:   if (r_occ != 3'd0 && !bus.ft_txe_n_i) r_state <= STREAM;
                STREAM: if (bus.ft_txe_n_i) r_state <= STALL;
                        else if (r_occ == 3'd0 && !r_rd_pend) r_state <= IDLE;
                STALL:  if (!bus.ft_txe_n_i && r_occ != 3'd0) r_state <= STREAM;
                SUSP:   r_state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_n) !(w_push && !w_pop && r_occ == 3'd4));

    assign bus.fifo_ren_o = w_ren;
    assign bus.ft_wr_n_o  = r_wr_n;
    assign bus.ft_data_o  = r_data;
    assign bus.words_o    = r_words;
    assign bus.busy_o     = r_busy;

`ifdef FT_TX_FLUSH_EN
    localparam int IW = $clog2(FLUSH_IDLE + 1);
    logic          r_armed, r_siwua;
    logic [IW-1:0] r_idle;
    logic          w_idle;

    // Suspend blocks counting, so a flush can never be issued while suspended
    assign w_idle = r_occ == 3'd0 && bus.fifo_empty_i && !r_rd_pend && bus.ft_suspend_n_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_idle  <= '0;
            r_siwua <= 1'b1;
        end else begin
            r_siwua <= 1'b1;
            if (w_pop) begin
                r_armed <= 1'b1;
                r_idle  <= '0;
            end else if (r_armed && w_idle && r_idle == IW'(FLUSH_IDLE - 1)) begin
                r_siwua <= 1'b0;
                r_armed <= 1'b0;
                r_idle  <= '0;
            end else if (r_armed && w_idle) r_idle <= r_idle + IW'(1);
            else r_idle <= '0;
        end
    end

    assign bus.ft_siwua_n_o = r_siwua;
`else
    assign bus.ft_siwua_n_o = 1'b1;
`endif
endmodule

// File: tb/tb_ft245_sync_tx.sv
// tb_ft245_sync_tx: randomized bench with upstream-FIFO and host scoreboards for ft245_sync_tx.
module tb_ft245_sync_tx;
`ifdef FT_TX_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif
    localparam int FLUSH_IDLE = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ft245_sync_tx_if #(.WIDTH(8), .CNT_WIDTH(32)) bus ();
    ft245_sync_tx #(.WIDTH(8), .CNT_WIDTH(32)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [7:0] src_q[$], exp_q[$], host_q[$];
    logic [7:0] pend_data, want_d;
    int         vectors, errors, mwords, inflight, icnt;
    bit         prev_susp, s_ren, s_acc, pend, armed, exp_siw;

    // Upstream FIFO, host and flush model: decides at negedge what the next posedge does
    initial begin
        bus.fifo_empty_i = 1'b1;
        bus.fifo_rdata_i = '0;
        exp_siw = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                {mwords, inflight, icnt} = '0;
                {prev_susp, pend, armed} = '0;
                exp_siw = 1'b1;
            end else begin
                s_ren = bus.fifo_ren_o;
                s_acc = !bus.ft_wr_n_o && !bus.ft_txe_n_i;
                vectors++;
                if (bus.words_o !== 32'(mwords)) begin
                    errors++; $display("FAIL words_o: got %0d, want %0d", bus.words_o, mwords);
                end
                vectors++;
                if (bus.busy_o !== (inflight != 0)) begin
                    errors++; $display("FAIL busy_o: got %b, want %b", bus.busy_o, inflight != 0);
                end
                vectors++;
                if (bus.ft_siwua_n_o !== exp_siw) begin
                    errors++; $display("FAIL siwua_n: got %b, want %b", bus.ft_siwua_n_o, exp_siw);
                end
                if (s_ren) begin
                    vectors++;
                    if (inflight >= 3 || !bus.ft_suspend_n_i) begin
                        errors++; $display("FAIL ren_limit: got ren=1, want 0 (in flight %0d, suspend_n %b)", inflight, bus.ft_suspend_n_i);
                    end
                end
                if (prev_susp) begin
                    vectors++;
                    if (bus.ft_wr_n_o !== 1'b1) begin
                        errors++; $display("FAIL wr_n_susp: got %b, want 1", bus.ft_wr_n_o);
                    end
                end
                exp_siw = 1'b1;
                if (s_acc) begin
                    armed = FLUSH_EN;
                    icnt = 0;
                end else if (armed && inflight == 0 && bus.fifo_empty_i && bus.ft_suspend_n_i) begin
                    icnt++;
                    if (icnt == FLUSH_IDLE) begin
                        exp_siw = 1'b0;
                        armed = 1'b0;
                        icnt = 0;
                    end
                end else icnt = 0;
                if (s_acc) begin
                    want_d = exp_q.size() != 0 ? exp_q[0] : 8'hxx;
                    vectors++;
                    if (exp_q.size() == 0 || bus.ft_data_o !== want_d) begin
                        errors++; $display("FAIL accept_data: got %h, want %h", bus.ft_data_o, want_d);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    host_q.push_back(bus.ft_data_o);
                    mwords++;
                    inflight--;
                end
                pend = s_ren;
                if (s_ren) begin
                    pend_data = src_q.size() != 0 ? src_q.pop_front() : 8'hxx;
                    exp_q.push_back(pend_data);
                    inflight++;
                end
                prev_susp = !bus.ft_suspend_n_i;
            end
            @(posedge clk);
            #1;
            if (pend) bus.fifo_rdata_i = pend_data;
            bus.fifo_empty_i = src_q.size() == 0;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int lim, output int n);
        bus.ft_txe_n_i = 1'b0;
        bus.ft_suspend_n_i = 1'b1;
        n = 0;
        while (n < lim && (src_q.size() != 0 || exp_q.size() != 0)) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] got[6];
        logic [31:0] want[6] = '{0, 1, 0, 1, 0, 0};
        string       nm[6] = '{"fifo_ren_o", "ft_wr_n_o", "ft_data_o", "ft_siwua_n_o", "words_o", "busy_o"};
        bus.ft_txe_n_i = 1'b1;
        bus.ft_suspend_n_i = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        got = '{32'(bus.fifo_ren_o), 32'(bus.ft_wr_n_o), 32'(bus.ft_data_o), 32'(bus.ft_siwua_n_o), bus.words_o, 32'(bus.busy_o)};
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                errors++; $display("FAIL reset %s: got %0h, want %0h", nm[i], got[i], want[i]);
            end
        end
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        int h0, n;
        h0 = host_q.size();
        for (int i = 0; i < 256; i++) src_q.push_back(8'(i));
        drain(400, n);
        vectors++;
        if (n > 264) begin
            errors++; $display("FAIL stream_cycles: got %0d, want <= 264", n);
        end
        vectors++;
        if (bus.words_o !== 32'd256) begin
            errors++; $display("FAIL stream_words: got %0d, want 256", bus.words_o);
        end
        for (int i = 0; i < 256 && h0 + i < host_q.size(); i++) begin
            vectors++;
            if (host_q[h0 + i] !== 8'(i)) begin
                errors++; $display("FAIL stream_seq[%0d]: got %h, want %h", i, host_q[h0 + i], 8'(i));
            end
        end
    endtask

    task automatic test_txe_pause;
        int h0, n;
        bit raised = 1'b0;
        h0 = host_q.size();
        for (int i = 0; i < 64; i++) src_q.push_back(8'(i));
        for (int i = 0; i < 200 && !raised; i++) begin
            cyc(1);
            if (host_q.size() > h0 && host_q[$] == 8'h10) begin
                bus.ft_txe_n_i = 1'b1;
                cyc(5);
                bus.ft_txe_n_i = 1'b0;
                raised = 1'b1;
            end
        end
        drain(300, n);
        vectors++;
        if (!raised || n >= 300 || host_q.size() != h0 + 64) begin
            errors++; $display("FAIL pause_flow: got %0d words (raised %b), want 64", host_q.size() - h0, raised);
        end else begin
            vectors++;
            if (host_q[h0 + 17] !== 8'h11) begin
                errors++; $display("FAIL pause_next: got %h, want 11", host_q[h0 + 17]);
            end
        end
    endtask

    task automatic test_toggle;
        int h0, n;
        h0 = host_q.size();
        for (int i = 0; i < 300; i++) src_q.push_back(8'(i + 5));
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            bus.ft_txe_n_i = ~bus.ft_txe_n_i;
        end
        drain(400, n);
        vectors++;
        if (host_q.size() != h0 + 300) begin
            errors++; $display("FAIL toggle_count: got %0d, want 300", host_q.size() - h0);
        end
        for (int i = h0 + 1; i < host_q.size(); i++) begin
            vectors++;
            if (host_q[i] !== 8'(host_q[i - 1] + 8'd1)) begin
                errors++; $display("FAIL toggle_seq[%0d]: got %h, want %h", i - h0, host_q[i], 8'(host_q[i - 1] + 8'd1));
            end
        end
    endtask

    task automatic test_suspend;
        int h0, n;
        logic [31:0] ws;
        h0 = host_q.size();
        for (int i = 0; i < 100; i++) src_q.push_back(8'(i + 100));
        cyc(20);
        bus.ft_suspend_n_i = 1'b0;
        cyc(1);
        ws = bus.words_o;
        cyc(19);
        vectors++;
        if (bus.words_o !== ws) begin
            errors++; $display("FAIL susp_hold: got %0d, want %0d", bus.words_o, ws);
        end
        drain(300, n);
        vectors++;
        if (host_q.size() != h0 + 100) begin
            errors++; $display("FAIL susp_count: got %0d, want 100", host_q.size() - h0);
        end
        for (int i = h0 + 1; i < host_q.size(); i++) begin
            vectors++;
            if (host_q[i] !== 8'(host_q[i - 1] + 8'd1)) begin
                errors++; $display("FAIL susp_seq[%0d]: got %h, want %h", i - h0, host_q[i], 8'(host_q[i - 1] + 8'd1));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] got[6];
        logic [31:0] want[6] = '{0, 1, 0, 1, 0, 0};
        string       nm[6] = '{"fifo_ren_o", "ft_wr_n_o", "ft_data_o", "ft_siwua_n_o", "words_o", "busy_o"};
        logic [7:0]  head;
        int          h0, n, rem;
        for (int i = 0; i < 100; i++) src_q.push_back(8'(i + 37));
        cyc(30);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        got = '{32'(bus.fifo_ren_o), 32'(bus.ft_wr_n_o), 32'(bus.ft_data_o), 32'(bus.ft_siwua_n_o), bus.words_o, 32'(bus.busy_o)};
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                errors++; $display("FAIL rst_mid %s: got %0h, want %0h", nm[i], got[i], want[i]);
            end
        end
        cyc(2);
        rst_n = 1'b1;
        h0 = host_q.size();
        head = src_q[0];
        rem = src_q.size();
        drain(300, n);
        vectors++;
        if (host_q.size() <= h0 || host_q[h0] !== head) begin
            errors++; $display("FAIL rst_mid_head: got %h, want %h", host_q.size() > h0 ? host_q[h0] : 8'hxx, head);
        end
        vectors++;
        if (bus.words_o !== 32'(rem)) begin
            errors++; $display("FAIL rst_mid_words: got %0d, want %0d", bus.words_o, rem);
        end
    endtask

    task automatic test_random;
        int w0, p, n;
        w0 = mwords;
        p = 0;
        for (int i = 0; i < 1500; i++) begin
            cyc(1);
            bus.ft_txe_n_i = $urandom_range(0, 3) == 0;
            bus.ft_suspend_n_i = $urandom_range(0, 29) != 0;
            if ($urandom_range(0, 2) != 0) begin
                src_q.push_back(8'($urandom));
                p++;
            end
        end
        drain(400, n);
        vectors++;
        if (bus.words_o !== 32'(w0 + p)) begin
            errors++; $display("FAIL random_words: got %0d, want %0d", bus.words_o, w0 + p);
        end
    endtask

    task automatic test_flush;
        int lows, last, pulse;
        logic [31:0] pw;
        {lows, last, pulse} = '0;
        pw = bus.words_o;
        for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
        bus.ft_txe_n_i = 1'b0;
        bus.ft_suspend_n_i = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            cyc(1);
            if (bus.words_o != pw) last = c;
            pw = bus.words_o;
            if (bus.ft_siwua_n_o !== 1'b1) begin
                lows++;
                pulse = c;
            end
        end
        vectors++;
        if (lows != int'(FLUSH_EN)) begin
            errors++; $display("FAIL flush_pulses: got %0d, want %0d", lows, int'(FLUSH_EN));
        end
`ifdef FT_TX_FLUSH_EN
        vectors++;
        if (pulse - last != FLUSH_IDLE) begin
            errors++; $display("FAIL flush_delay: got %0d, want %0d", pulse - last, FLUSH_IDLE);
        end
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        {vectors, errors} = '0;
        test_reset;
        test_stream;
        test_txe_pause;
        test_toggle;
        test_suspend;
        test_reset_mid;
        test_random;
        test_flush;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
